// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the MSRV32 machine-mode trap controller:
//   - FSM state encoding (STATE_WFI only present when MSRV32_WFI_EN is defined)
//   - mcause exception/interrupt codes
//   - pc_src_out encodings
//   - SYSTEM opcode and funct3/funct7/rs2 patterns for ECALL/EBREAK/MRET/WFI
// Build option: `define MSRV32_WFI_EN to enable the WFI stall state.
// ---------------------------------------------------------------------------
package msrv32_pkg;

    typedef enum logic [2:0] {
        STATE_RESET       = 3'd0,
        STATE_OPERATING   = 3'd1,
        STATE_TRAP_TAKEN  = 3'd2,
        STATE_TRAP_RETURN = 3'd3
`ifdef MSRV32_WFI_EN
        ,
        STATE_WFI         = 3'd4
`endif
    } state_e;

    // Exception cause codes (i_or_e = 0)
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    // Interrupt cause codes (i_or_e = 1)
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // PC source select
    localparam logic [1:0] PC_SRC_BOOT    = 2'b00;
    localparam logic [1:0] PC_SRC_EPC     = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP    = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT_PC = 2'b11;

    // SYSTEM instruction decode patterns
    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
    localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
    localparam logic [4:0] RS2_ECALL     = 5'b00000;
    localparam logic [6:0] FUNCT7_EBREAK = 7'b0000000;
    localparam logic [4:0] RS2_EBREAK    = 5'b00001;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] RS2_MRET      = 5'b00010;
    localparam logic [6:0] FUNCT7_WFI    = 7'b0001000;
    localparam logic [4:0] RS2_WFI       = 5'b00101;

    // Misaligned exceptions are the ones the load/store/fetch units care about.
    function automatic logic is_misaligned_cause(input logic [3:0] cause);
        return (cause == CAUSE_INSTR_MISALIGNED) ||
               (cause == CAUSE_LOAD_MISALIGNED)  ||
               (cause == CAUSE_STORE_MISALIGNED);
    endfunction

endpackage

// File: rtl/msrv32_sys_instr_dec.sv
// ---------------------------------------------------------------------------
// msrv32_sys_instr_dec
// Combinational decode of privileged SYSTEM instructions.
// Inputs : opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in,
//          rd_addr_in (raw instruction fields)
// Outputs: ecall_out, ebreak_out, mret_out, wfi_out (wfi_out only when
//          MSRV32_WFI_EN is defined)
// ---------------------------------------------------------------------------
module msrv32_sys_instr_dec
    import msrv32_pkg::*;
(
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    output logic       ecall_out,
    output logic       ebreak_out,
`ifdef MSRV32_WFI_EN
    output logic       wfi_out,
`endif
    output logic       mret_out
);

    // All four privileged instructions share opcode, funct3 and zero rs1/rd;
    // they differ only in funct7/rs2.
    logic sys_base;

    assign sys_base = (opcode_6_to_2_in == OPCODE_SYSTEM) &&
                      (funct3_in == FUNCT3_PRIV) &&
                      (rs1_addr_in == 5'd0) &&
                      (rd_addr_in == 5'd0);

    assign ecall_out  = sys_base && (funct7_in == FUNCT7_ECALL)  && (rs2_addr_in == RS2_ECALL);
    assign ebreak_out = sys_base && (funct7_in == FUNCT7_EBREAK) && (rs2_addr_in == RS2_EBREAK);
    assign mret_out   = sys_base && (funct7_in == FUNCT7_MRET)   && (rs2_addr_in == RS2_MRET);
`ifdef MSRV32_WFI_EN
    assign wfi_out    = sys_base && (funct7_in == FUNCT7_WFI)    && (rs2_addr_in == RS2_WFI);
`endif

endmodule

// File: rtl/msrv32_machine_control.sv
// ---------------------------------------------------------------------------
// msrv32_machine_control
// Machine-mode trap controller: sequences trap entry and MRET return, selects
// the PC source and flushes the fetched instruction.
//
// Parameter: RESET_HOLD (1..15) cycles spent in STATE_RESET after release.
// Build option: `define MSRV32_WFI_EN adds STATE_WFI (WFI stalls until an
//               enabled interrupt is pending); otherwise WFI retires as a NOP.
//
// Inputs : clk_in, rst_n_in (async, active-low), decoder exception flags
//          (illegal_instr_in, misaligned_{load,store,instr}_in), instruction
//          fields, mstatus.MIE (mie_in), mie enables, mip pending bits.
// Outputs: pc_src_out, flush_out, trap_taken_out, set_epc_out, set_cause_out,
//          mie_clear_out, mie_set_out, cause_out, i_or_e_out,
//          misaligned_exception_out, instret_inc_out, stall_out.
// ---------------------------------------------------------------------------
module msrv32_machine_control
    import msrv32_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       misaligned_exception_out,
    output logic       instret_inc_out,
    output logic       stall_out
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_e     state_q;
    logic [3:0] hold_cnt_q;
    logic [3:0] cause_q;
    logic       i_or_e_q;

    // -----------------------------------------------------------------------
    // System instruction decode
    // -----------------------------------------------------------------------
    logic is_ecall;
    logic is_ebreak;
    logic is_mret;
`ifdef MSRV32_WFI_EN
    logic is_wfi;
`endif

    msrv32_sys_instr_dec u_sys_instr_dec (
        .opcode_6_to_2_in (opcode_6_to_2_in),
        .funct3_in        (funct3_in),
        .funct7_in        (funct7_in),
        .rs1_addr_in      (rs1_addr_in),
        .rs2_addr_in      (rs2_addr_in),
        .rd_addr_in       (rd_addr_in),
        .ecall_out        (is_ecall),
        .ebreak_out       (is_ebreak),
`ifdef MSRV32_WFI_EN
        .wfi_out          (is_wfi),
`endif
        .mret_out         (is_mret)
    );

    // -----------------------------------------------------------------------
    // Trap detection and cause prioritisation
    // -----------------------------------------------------------------------
    logic       irq_enabled_pending;  // enabled and pending, mstatus.MIE ignored
    logic       irq_d;
    logic       exc_d;
    logic       trap_d;
    logic [3:0] trap_cause_d;
    logic       trap_i_or_e_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        trap_cause_d  = CAUSE_INSTR_MISALIGNED;
        trap_i_or_e_d = 1'b0;

        irq_enabled_pending = (meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in);
        irq_d  = mie_in & irq_enabled_pending;
        exc_d  = illegal_instr_in | misaligned_instr_in | is_ecall | is_ebreak |
                 misaligned_store_in | misaligned_load_in;
        trap_d = irq_d | exc_d;

        // Interrupts win over exceptions; within each group the first match wins.
        if (irq_d) begin
            trap_i_or_e_d = 1'b1;
            if (meie_in & meip_in)      trap_cause_d = CAUSE_MEI;
            else if (msie_in & msip_in) trap_cause_d = CAUSE_MSI;
            else                        trap_cause_d = CAUSE_MTI;
        end else if (illegal_instr_in) begin
            trap_cause_d = CAUSE_ILLEGAL_INSTR;
        end else if (misaligned_instr_in) begin
            trap_cause_d = CAUSE_INSTR_MISALIGNED;
        end else if (is_ecall) begin
            trap_cause_d = CAUSE_ECALL_M;
        end else if (is_ebreak) begin
            trap_cause_d = CAUSE_BREAKPOINT;
        end else if (misaligned_store_in) begin
            trap_cause_d = CAUSE_STORE_MISALIGNED;
        end else if (misaligned_load_in) begin
            trap_cause_d = CAUSE_LOAD_MISALIGNED;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM. cause/i_or_e are only written on trap entry so they keep
    // the last trap's values for the CSR file to read afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n_in) begin
            state_q    <= STATE_RESET;
            hold_cnt_q <= 4'd0;
            cause_q    <= 4'd0;
            i_or_e_q   <= 1'b0;
        end else begin
            case (state_q)
                STATE_RESET: begin
                    hold_cnt_q <= hold_cnt_q + 4'd1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= STATE_OPERATING;
                    end
                end
                STATE_OPERATING: begin
                    if (trap_d) begin
                        state_q  <= STATE_TRAP_TAKEN;
                        cause_q  <= trap_cause_d;
                        i_or_e_q <= trap_i_or_e_d;
                    end else if (is_mret) begin
                        state_q <= STATE_TRAP_RETURN;
`ifdef MSRV32_WFI_EN
                    end else if (is_wfi) begin
                        state_q <= STATE_WFI;
`endif
                    end
                end
                // One-cycle states: the redirect happens here, then the core
                // resumes at the new PC. Inputs are ignored meanwhile.
                STATE_TRAP_TAKEN:  state_q <= STATE_OPERATING;
                STATE_TRAP_RETURN: state_q <= STATE_OPERATING;
`ifdef MSRV32_WFI_EN
                STATE_WFI: begin
                    // Wake on any enabled pending interrupt even with MIE=0;
                    // the trap itself is then decided back in OPERATING.
                    if (irq_enabled_pending) begin
                        state_q <= STATE_OPERATING;
                    end
                end
`endif
                default: state_q <= STATE_RESET;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the state register. Only instret_inc_out looks at
    // inputs: a trap or MRET in this cycle means the instruction does not retire.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_src_out      = PC_SRC_BOOT;
        flush_out       = 1'b0;
        trap_taken_out  = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        stall_out       = 1'b0;
        misaligned_exception_out = 1'b0;

        case (state_q)
            STATE_RESET: begin
                pc_src_out = PC_SRC_BOOT;
                flush_out  = 1'b1;
            end
            STATE_OPERATING: begin
                pc_src_out      = PC_SRC_NEXT_PC;
                instret_inc_out = ~trap_d & ~is_mret;
            end
            STATE_TRAP_TAKEN: begin
                pc_src_out     = PC_SRC_TRAP;
                flush_out      = 1'b1;
                trap_taken_out = 1'b1;
                set_epc_out    = 1'b1;
                set_cause_out  = 1'b1;
                mie_clear_out  = 1'b1;
                misaligned_exception_out = ~i_or_e_q & is_misaligned_cause(cause_q);
            end
            STATE_TRAP_RETURN: begin
                pc_src_out  = PC_SRC_EPC;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
            end
`ifdef MSRV32_WFI_EN
            STATE_WFI: begin
                pc_src_out = PC_SRC_NEXT_PC;
                stall_out  = 1'b1;
            end
`endif
            default: begin
                pc_src_out = PC_SRC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign cause_out  = cause_q;
    assign i_or_e_out = i_or_e_q;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// ---------------------------------------------------------------------------
// tb_msrv32_machine_control
// Self-checking bench for msrv32_machine_control: directed scenarios with
// literal expectations, then randomized traffic compared every falling clock
// edge against a behavioural model of the trap controller.
// ---------------------------------------------------------------------------
module tb_msrv32_machine_control;

    localparam int HOLD = 1;

    // Full 32-bit encodings of the privileged instructions
    localparam logic [31:0] W_ECALL  = 32'h0000_0073;
    localparam logic [31:0] W_EBREAK = 32'h0010_0073;
    localparam logic [31:0] W_MRET   = 32'h3020_0073;
    localparam logic [31:0] W_WFI    = 32'h1050_0073;
    localparam logic [31:0] W_NOP    = 32'h0000_0013;

    // Model modes
    localparam int M_RESET = 0;
    localparam int M_RUN   = 1;
    localparam int M_TRAP  = 2;
    localparam int M_RET   = 3;
    localparam int M_WFI   = 4;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
    logic [4:0] opcode_6_to_2_in, rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;

    logic [1:0] pc_src_out;
    logic       flush_out, trap_taken_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out;
    logic [3:0] cause_out;
    logic       i_or_e_out, misaligned_exception_out, instret_inc_out, stall_out;

    msrv32_machine_control #(.RESET_HOLD(HOLD)) dut (
        .clk_in                   (clk_in),
        .rst_n_in                 (rst_n_in),
        .illegal_instr_in         (illegal_instr_in),
        .misaligned_load_in       (misaligned_load_in),
        .misaligned_store_in      (misaligned_store_in),
        .misaligned_instr_in      (misaligned_instr_in),
        .opcode_6_to_2_in         (opcode_6_to_2_in),
        .funct3_in                (funct3_in),
        .funct7_in                (funct7_in),
        .rs1_addr_in              (rs1_addr_in),
        .rs2_addr_in              (rs2_addr_in),
        .rd_addr_in               (rd_addr_in),
        .mie_in                   (mie_in),
        .meie_in                  (meie_in),
        .mtie_in                  (mtie_in),
        .msie_in                  (msie_in),
        .meip_in                  (meip_in),
        .mtip_in                  (mtip_in),
        .msip_in                  (msip_in),
        .pc_src_out               (pc_src_out),
        .flush_out                (flush_out),
        .trap_taken_out           (trap_taken_out),
        .set_epc_out              (set_epc_out),
        .set_cause_out            (set_cause_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .cause_out                (cause_out),
        .i_or_e_out               (i_or_e_out),
        .misaligned_exception_out (misaligned_exception_out),
        .instret_inc_out          (instret_inc_out),
        .stall_out                (stall_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    int m_mode  = M_RESET;
    int m_cycles = 0;
    int m_cause = 0;
    bit m_intr  = 1'b0;

    function automatic logic [31:0] cur_word();
        return {funct7_in, rs2_addr_in, rs1_addr_in, funct3_in, rd_addr_in, opcode_6_to_2_in, 2'b11};
    endfunction

    function automatic bit wfi_supported();
`ifdef MSRV32_WFI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit any_enabled_pending();
        return (meie_in && meip_in) || (msie_in && msip_in) || (mtie_in && mtip_in);
    endfunction

    // What trap (if any) the current inputs request while running.
    function automatic void model_trap(output bit take, output int cause, output bit intr);
        logic [31:0] w;
        w = cur_word();
        take = 1'b1;
        intr = 1'b0;
        cause = 0;
        if (mie_in && any_enabled_pending()) begin
            intr = 1'b1;
            if (meie_in && meip_in)      cause = 11;
            else if (msie_in && msip_in) cause = 3;
            else                         cause = 7;
        end
        else if (illegal_instr_in)    cause = 2;
        else if (misaligned_instr_in) cause = 0;
        else if (w == W_ECALL)        cause = 11;
        else if (w == W_EBREAK)       cause = 3;
        else if (misaligned_store_in) cause = 6;
        else if (misaligned_load_in)  cause = 4;
        else                          take = 1'b0;
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        bit take;
        int cause;
        bit intr;
        if (!rst_n_in) begin
            m_mode   <= M_RESET;
            m_cycles <= 0;
            m_cause  <= 0;
            m_intr   <= 1'b0;
        end else begin
            model_trap(take, cause, intr);
            case (m_mode)
                M_RESET: begin
                    m_cycles <= m_cycles + 1;
                    if (m_cycles + 1 >= HOLD) m_mode <= M_RUN;
                end
                M_RUN: begin
                    if (take) begin
                        m_mode  <= M_TRAP;
                        m_cause <= cause;
                        m_intr  <= intr;
                    end else if (cur_word() == W_MRET) begin
                        m_mode <= M_RET;
                    end else if (wfi_supported() && cur_word() == W_WFI) begin
                        m_mode <= M_WFI;
                    end
                end
                M_WFI:   if (any_enabled_pending()) m_mode <= M_RUN;
                default: m_mode <= M_RUN;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_in) begin
        bit take;
        int cause;
        bit intr;
        int e_pc;
        bit e_flush, e_trap, e_ret, e_instret, e_stall, e_mis;
        if (!done) begin
            model_trap(take, cause, intr);
            e_pc = 0; e_flush = 0; e_trap = 0; e_ret = 0; e_instret = 0; e_stall = 0; e_mis = 0;
            case (m_mode)
                M_RESET: begin e_pc = 0; e_flush = 1; end
                M_RUN: begin
                    e_pc = 3;
                    e_instret = !take && (cur_word() != W_MRET);
                end
                M_TRAP: begin
                    e_pc = 2; e_flush = 1; e_trap = 1;
                    e_mis = !m_intr && (m_cause == 0 || m_cause == 4 || m_cause == 6);
                end
                M_RET: begin e_pc = 1; e_flush = 1; e_ret = 1; end
                default: begin e_pc = 3; e_stall = 1; end
            endcase
            check("pc_src", 32'(pc_src_out), 32'(e_pc));
            check("flush", 32'(flush_out), 32'(e_flush));
            check("trap_group", {29'd0, trap_taken_out, set_epc_out, set_cause_out},
                  {29'd0, e_trap, e_trap, e_trap});
            check("mie_clear", 32'(mie_clear_out), 32'(e_trap));
            check("mie_set", 32'(mie_set_out), 32'(e_ret));
            check("cause", 32'(cause_out), 32'(m_cause));
            check("i_or_e", 32'(i_or_e_out), 32'(m_intr));
            check("misaligned_exc", 32'(misaligned_exception_out), 32'(e_mis));
            check("instret_inc", 32'(instret_inc_out), 32'(e_instret));
            check("stall", 32'(stall_out), 32'(e_stall));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic set_word(input logic [31:0] w);
        {funct7_in, rs2_addr_in, rs1_addr_in, funct3_in, rd_addr_in, opcode_6_to_2_in} = w[31:2];
    endtask

    task automatic clear_inputs();
        illegal_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0; misaligned_instr_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0; meip_in = 0; mtip_in = 0; msip_in = 0;
        set_word(W_NOP);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic random_inputs();
        logic [31:0] w;
        int sel;
        illegal_instr_in    = ($urandom % 16) == 0;
        misaligned_instr_in = ($urandom % 16) == 0;
        misaligned_store_in = ($urandom % 12) == 0;
        misaligned_load_in  = ($urandom % 12) == 0;
        mie_in  = $urandom % 2;
        meie_in = $urandom % 2; msie_in = $urandom % 2; mtie_in = $urandom % 2;
        meip_in = ($urandom % 8) == 0;
        msip_in = ($urandom % 8) == 0;
        mtip_in = ($urandom % 8) == 0;
        sel = $urandom % 10;
        case (sel)
            0: w = W_ECALL;
            1: w = W_EBREAK;
            2, 3: w = W_MRET;
            4: w = W_WFI;
            5: begin
                case ($urandom % 4)
                    0: w = W_ECALL;
                    1: w = W_EBREAK;
                    2: w = W_MRET;
                    default: w = W_WFI;
                endcase
                w = w ^ (32'd1 << $urandom_range(31, 7));
            end
            default: w = $urandom;
        endcase
        set_word(w);
    endtask

    // -----------------------------------------------------------------------
    // Directed scenarios, then random traffic
    // -----------------------------------------------------------------------
    initial begin
        clear_inputs();
        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        #1 rst_n_in = 1'b1;

        // Reset release: one cycle in boot state, then running
        #1;
        check("t1_boot_pc", 32'(pc_src_out), 32'd0);
        check("t1_boot_flush", 32'(flush_out), 32'd1);
        step();
        check("t1_run_pc", 32'(pc_src_out), 32'd3);
        check("t1_run_instret", 32'(instret_inc_out), 32'd1);

        // Illegal instruction
        illegal_instr_in = 1'b1;
        #1 check("t2_no_retire", 32'(instret_inc_out), 32'd0);
        step();
        clear_inputs();
        #1;
        check("t2_trap_taken", 32'(trap_taken_out), 32'd1);
        check("t2_pc_trap", 32'(pc_src_out), 32'd2);
        check("t2_cause", 32'(cause_out), 32'd2);
        check("t2_i_or_e", 32'(i_or_e_out), 32'd0);
        step();
        check("t2_back_pc", 32'(pc_src_out), 32'd3);

        // Interrupt beats exception, MEI beats MTI
        mie_in = 1; meie_in = 1; meip_in = 1; mtie_in = 1; mtip_in = 1;
        set_word(W_ECALL);
        step();
        clear_inputs();
        #1;
        check("t3_cause", 32'(cause_out), 32'd11);
        check("t3_i_or_e", 32'(i_or_e_out), 32'd1);
        check("t3_mis_exc", 32'(misaligned_exception_out), 32'd0);
        step();

        // MRET
        set_word(W_MRET);
        #1 check("t4_no_retire", 32'(instret_inc_out), 32'd0);
        step();
        clear_inputs();
        #1;
        check("t4_pc_epc", 32'(pc_src_out), 32'd1);
        check("t4_mie_set", 32'(mie_set_out), 32'd1);
        check("t4_flush", 32'(flush_out), 32'd1);
        step();
        check("t4_back_pc", 32'(pc_src_out), 32'd3);

        // Store beats load; then reset in the middle of trap entry
        misaligned_store_in = 1; misaligned_load_in = 1;
        step();
        clear_inputs();
        #1;
        check("t5_cause", 32'(cause_out), 32'd6);
        check("t5_mis_exc", 32'(misaligned_exception_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("t5_rst_pc", 32'(pc_src_out), 32'd0);
        check("t5_rst_cause", 32'(cause_out), 32'd0);
        check("t5_rst_trap", 32'(trap_taken_out), 32'd0);
        @(negedge clk_in);
        #1 rst_n_in = 1'b1;
        step();
        check("t5_run_pc", 32'(pc_src_out), 32'd3);

`ifdef MSRV32_WFI_EN
        // WFI stalls until an enabled interrupt is pending
        mie_in = 1; mtie_in = 1;
        set_word(W_WFI);
        step();
        set_word(W_NOP);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_stall", 32'(stall_out), 32'd1);
            check("t6_no_retire", 32'(instret_inc_out), 32'd0);
            step();
        end
        mtip_in = 1;
        step();
        check("t6_wake_pc", 32'(pc_src_out), 32'd3);
        check("t6_wake_stall", 32'(stall_out), 32'd0);
        step();
        clear_inputs();
        #1;
        check("t6_trap", 32'(trap_taken_out), 32'd1);
        check("t6_cause", 32'(cause_out), 32'd7);
        check("t6_i_or_e", 32'(i_or_e_out), 32'd1);
        step();
`else
        // WFI retires as a NOP
        set_word(W_WFI);
        #1;
        check("t6_wfi_retire", 32'(instret_inc_out), 32'd1);
        check("t6_wfi_stall", 32'(stall_out), 32'd0);
        step();
        clear_inputs();
        #1;
        check("t6_wfi_pc", 32'(pc_src_out), 32'd3);
        check("t6_wfi_flush", 32'(flush_out), 32'd0);
        step();
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 2000; n++) begin
            random_inputs();
            if (($urandom % 150) == 0) begin
                #1 rst_n_in = 1'b0;
                @(negedge clk_in);
                #1 rst_n_in = 1'b1;
            end
            step();
        end

        @(negedge clk_in);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv32_machine_control.md
Name: msrv32_machine_control

Overview:
Machine-mode trap controller for the MSRV32 RV32I core. It sits beside the instruction decoder and consumes the decoder's illegal-instruction and misaligned load/store flags. It combines these with CSR interrupt-enable/pending bits and system-instruction decode. It sequences trap entry and MRET return, drives the PC source select and pipeline flush, and produces trap_taken_out, which feeds the decoder's trap_taken_in.

Parameters:
RESET_HOLD, 1, number of cycles (1-15) spent in STATE_RESET after reset release before entering STATE_OPERATING.

Ports:
clk_in  input  1  core clock
rst_n_in  input  1  reset, asynchronous assert, active-low
illegal_instr_in  input  1  from decoder illegal_instr_out
misaligned_load_in  input  1  from decoder misalligned_load_out
misaligned_store_in  input  1  from decoder misalligned_store_out
misaligned_instr_in  input  1  branch/jump target bit 1 set
opcode_6_to_2_in  input  5  instr[6:2]
funct3_in  input  3  instr[14:12]
funct7_in  input  7  instr[31:25]
rs1_addr_in  input  5  instr[19:15]
rs2_addr_in  input  5  instr[24:20]
rd_addr_in  input  5  instr[11:7]
mie_in  input  1  mstatus.MIE
meie_in, mtie_in, msie_in  input  1 each  mie CSR enables
meip_in, mtip_in, msip_in  input  1 each  mip pending
pc_src_out  output  2  00 boot, 01 mepc, 10 trap vector, 11 next PC
flush_out  output  1  flush the fetched instruction
trap_taken_out  output  1  high in STATE_TRAP_TAKEN
set_epc_out, set_cause_out, mie_clear_out  output  1 each  CSR updates on trap entry
mie_set_out  output  1  CSR update on MRET
cause_out  output  4  latched cause code
i_or_e_out  output  1  1 = interrupt, 0 = exception
misaligned_exception_out  output  1  trap is a misaligned exception
instret_inc_out  output  1  instruction retired this cycle
stall_out  output  1  hold PC (WFI only)

Behaviour:
- Clock/reset: single clock clk_in. rst_n_in is asynchronous and active-low. On reset: state=RESET, cause=0, i_or_e=0, hold counter=0.
- Outputs are decoded from the state register, so there are no output glitches from inputs except instret_inc_out.
- System decode applies when opcode_6_to_2_in=11100, funct3=000, and rs1=rd=0:
  - ECALL: funct7=0000000, rs2=00000
  - EBREAK: funct7=0000000, rs2=00001
  - MRET: funct7=0011000, rs2=00010
  - WFI: funct7=0001000, rs2=00101
- Interrupt pending: irq = mie_in & ((meie&meip)|(msie&msip)|(mtie&mtip)).
- Interrupt priority and cause: MEI (cause 11), then MSI (3), then MTI (7).
- Exception priority and cause: illegal (2), then misaligned instr (0), then ECALL (11), then EBREAK (3), then misaligned store (6), then misaligned load (4).
- Interrupt beats exception. Trap beats MRET.
- States and transitions:
  - RESET: counter increments each cycle; when counter reaches RESET_HOLD-1, go to OPERATING.
  - OPERATING: if irq or any exception, go to TRAP_TAKEN and latch cause/i_or_e on that edge. Else if MRET, go to TRAP_RETURN. Else stay.
  - TRAP_TAKEN: go to OPERATING unconditionally. Inputs are ignored.
  - TRAP_RETURN: go to OPERATING unconditionally.
- Outputs per state:
  - RESET: pc_src=00, flush=1, all others 0.
  - OPERATING: pc_src=11, flush=0. instret_inc=1 only when no trap and no MRET is being taken this cycle.
  - TRAP_TAKEN: pc_src=10, flush=1, trap_taken=1, set_epc=set_cause=mie_clear=1. misaligned_exception=1 iff !i_or_e and cause is 0, 4 or 6.
  - TRAP_RETURN: pc_src=01, flush=1, mie_set=1.
- cause_out and i_or_e_out hold their latched values until the next trap entry.
- rst_n_in asserted in any state, including mid-trap, forces RESET immediately.
- Exactly one trap is taken per trap sequence. Back-to-back traps are separated by at least one OPERATING cycle.

Optional Feature:
MSRV32_WFI_EN
- Defined: a decoded WFI in OPERATING (with no trap pending) enters STATE_WFI. WFI outputs: pc_src=11, stall_out=1, instret_inc=0. Exit to OPERATING when any enabled interrupt is pending ((meie&meip)|(msie&msip)|(mtie&mtip)), regardless of mie_in. The trap is then taken from OPERATING if mie_in=1.
- Undefined: WFI executes as a NOP (retires, no stall). stall_out is tied 0 and STATE_WFI does not exist.

Decomposition:
- msrv32_pkg holds:
  - state enum (RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN, WFI)
  - cause code constants
  - pc_src encodings
  - SYSTEM opcode and funct7/rs2 constants for ECALL/EBREAK/MRET/WFI
- One sub-module: msrv32_sys_instr_dec, combinational, producing ecall/ebreak/mret/wfi flags.

Test Plan:
1. Reset release with RESET_HOLD=1 -> pc_src=00 and flush=1 for 1 cycle, then pc_src=11 and instret_inc=1.
2. OPERATING with illegal_instr_in=1 -> next cycle TRAP_TAKEN: trap_taken=1, pc_src=10, cause=2, i_or_e=0; following cycle pc_src=11.
3. mie=1, meie=meip=1, mtie=mtip=1, and ECALL decoded together -> cause=11, i_or_e=1, misaligned_exception=0.
4. MRET with mie_in=0 and no exception -> TRAP_RETURN: pc_src=01, mie_set=1, flush=1; then OPERATING.
5. misaligned_store_in=1 and misaligned_load_in=1 -> cause=6, misaligned_exception=1. Assert rst_n_in low during TRAP_TAKEN -> immediately pc_src=00 and cause=0.
6. With MSRV32_WFI_EN defined: WFI -> stall_out=1 for N cycles; raise mtip with mtie=1 and mie=1 -> OPERATING, then TRAP_TAKEN with cause=7, i_or_e=1.
